// File: rtl/ndma_pkg.sv
// Shared types and helpers for the NanoDMA OBI memory subordinate.
//   AID_W          : width of the OBI transaction id
//   ndma_resp_t    : one queued response {rdata, rid, err}
//   ndma_be_merge  : byte-lane merge of write data over an existing word
package ndma_pkg;

    localparam int unsigned AID_W = 4;

    typedef struct packed {
        logic [31:0]      rdata;
        logic [AID_W-1:0] rid;
        logic             err;
    } ndma_resp_t;

    function automatic logic [31:0] ndma_be_merge(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ndma_resp_fifo.sv
// In-order response FIFO.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i: enqueue one entry (ignored when full unless popping)
//   pop_i        : dequeue head (ignored when empty)
//   full_o/empty_o/head_o : status and current head entry
// Simultaneous push and pop is legal even when full.
module ndma_resp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output T     head_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T              store_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        full_o  = (cnt_q == CW'(DEPTH));
        empty_o = (cnt_q == '0);
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        rd_d    = do_pop  ? ptr_inc(rd_q) : rd_q;
        wr_d    = do_push ? ptr_inc(wr_q) : wr_q;
        cnt_d   = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        head_o  = store_q[rd_q];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) store_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/ndma_obi_mem_sub.sv
// OBI subordinate fronting a small word-addressed memory.
//   clk_i, rst_i   : clock, synchronous active-high reset (clears memory too)
//   obi_req_i .. obi_aid_i : OBI request channel (req/addr/we/be/wdata/aid)
//   obi_gnt_o      : combinational grant
//   obi_rvalid_o .. obi_err_o : single-cycle response pulse (no rready)
//   stall_i        : test hook, holds gnt low while high
// Grants after GNT_WAIT held cycles, keeps up to MAX_OUTST responses in
// order, and presents each head entry RVALID_WAIT cycles after it reaches
// the head. Misaligned or out-of-window accesses answer with err=1.
module ndma_obi_mem_sub
    import ndma_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned GNT_WAIT    = 0,
    parameter int unsigned RVALID_WAIT = 0,
    parameter int unsigned MAX_OUTST   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             obi_req_i,
    output logic             obi_gnt_o,
    input  logic [31:0]      obi_addr_i,
    input  logic             obi_we_i,
    input  logic [3:0]       obi_be_i,
    input  logic [31:0]      obi_wdata_i,
    input  logic [AID_W-1:0] obi_aid_i,
    output logic             obi_rvalid_o,
    output logic [31:0]      obi_rdata_o,
    output logic [AID_W-1:0] obi_rid_o,
    output logic             obi_err_o,
    input  logic             stall_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned GW = $clog2(GNT_WAIT + 2);
    localparam int unsigned RW = $clog2(RVALID_WAIT + 2);
    localparam int unsigned OW = $clog2(MAX_OUTST + 1);

    logic [31:0]   mem_q [DEPTH];
    logic [GW-1:0] wait_q, wait_d;
    logic [RW-1:0] head_q, head_d;
    logic [OW-1:0] outst_q, outst_d;

    logic [32:0]   diff;
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          err_a, accept, pop, fifo_full, fifo_empty, unused_off;
    ndma_resp_t    push_entry, head_entry;

    always_comb begin
        // 33-bit subtraction: the borrow bit flags addresses below the window.
        diff       = {1'b0, obi_addr_i} - {1'b0, BASE_ADDR};
        off        = diff[31:0];
        idx        = off[AW+1:2];
        unused_off = ^off[1:0];
        err_a      = (|obi_addr_i[1:0]) | diff[32] | (off >= 32'(4 * DEPTH));

        // Held low during reset: the counters already read zero then.
        obi_gnt_o  = ~rst_i & obi_req_i & ~stall_i
                   & (wait_q == GW'(GNT_WAIT)) & (outst_q < OW'(MAX_OUTST));
        accept     = obi_gnt_o;

        push_entry.rdata = (obi_we_i | err_a) ? '0 : mem_q[idx];
        push_entry.rid   = obi_aid_i;
        push_entry.err   = err_a;

        obi_rvalid_o = ~rst_i & ~fifo_empty & (head_q == RW'(RVALID_WAIT));
        pop          = obi_rvalid_o;
        obi_rdata_o  = obi_rvalid_o ? head_entry.rdata : '0;
        obi_rid_o    = obi_rvalid_o ? head_entry.rid   : '0;
        obi_err_o    = obi_rvalid_o ? head_entry.err   : 1'b0;

        if (!obi_req_i || obi_gnt_o)        wait_d = '0;
        else if (wait_q != GW'(GNT_WAIT))   wait_d = wait_q + GW'(1);
        else                                wait_d = wait_q;

        if (pop || fifo_empty)              head_d = '0;
        else if (head_q != RW'(RVALID_WAIT)) head_d = head_q + RW'(1);
        else                                head_d = head_q;

        case ({accept, pop})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_q  <= '0;
            head_q  <= '0;
            outst_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wait_q  <= wait_d;
            head_q  <= head_d;
            outst_q <= outst_d;
            if (accept && obi_we_i && !err_a)
                mem_q[idx] <= ndma_be_merge(mem_q[idx], obi_wdata_i, obi_be_i);
        end
    end

    ndma_resp_fifo #(
        .DEPTH (MAX_OUTST),
        .T     (ndma_resp_t)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .data_i  (push_entry),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head_entry)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_ndma_obi_mem_sub.sv
// Three subordinates with different timing parameters, driven independently:
//   dut0: GNT_WAIT=0 RVALID_WAIT=0   dut1: GNT_WAIT=0 RVALID_WAIT=3
//   dut2: GNT_WAIT=2 RVALID_WAIT=0   (all MAX_OUTST=2, DEPTH=16, BASE=0x1000)
// A transaction-level model predicts gnt and responses every cycle.
module tb_ndma_obi_mem_sub;
    import ndma_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 16;
    localparam int          NI    = 3;
    localparam int          MO    = 2;

    logic clk = 1'b0;
    logic rst;
    logic             req [NI], we [NI], stall [NI], gnt [NI], rvalid [NI], err [NI];
    logic [3:0]       be [NI];
    logic [31:0]      addr [NI], wdata [NI], rdata [NI];
    logic [AID_W-1:0] aid [NI], rid [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ndma_obi_mem_sub #(
            .BASE_ADDR   (BASE),
            .DEPTH       (DEPTH),
            .GNT_WAIT    ((g == 2) ? 2 : 0),
            .RVALID_WAIT ((g == 1) ? 3 : 0),
            .MAX_OUTST   (MO)
        ) dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .obi_req_i    (req[g]),
            .obi_gnt_o    (gnt[g]),
            .obi_addr_i   (addr[g]),
            .obi_we_i     (we[g]),
            .obi_be_i     (be[g]),
            .obi_wdata_i  (wdata[g]),
            .obi_aid_i    (aid[g]),
            .obi_rvalid_o (rvalid[g]),
            .obi_rdata_o  (rdata[g]),
            .obi_rid_o    (rid[g]),
            .obi_err_o    (err[g]),
            .stall_i      (stall[g])
        );
    end

    function automatic int gw(input int k); return (k == 2) ? 2 : 0; endfunction
    function automatic int rw(input int k); return (k == 1) ? 3 : 0; endfunction

    // ---------------- reference model ----------------
    typedef struct packed { logic [31:0] d; logic [AID_W-1:0] id; logic e; } ent_t;
    logic [31:0]      mmem [NI][DEPTH];
    ent_t             mq [NI][4];
    int               mhead [NI], mcnt [NI], pend [NI];
    longint           hstart [NI];
    longint           cyc;
    bit               dec_acc [NI], dec_pop [NI];
    int               nresp [NI], issued [NI];
    logic [31:0]      obs_d [NI];
    logic [AID_W-1:0] obs_id [NI];
    logic             obs_e [NI];
    logic [AID_W-1:0] rid_hist [NI][4];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, k, got, exp, $time);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return ((la % 4) != 0) || (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * DEPTH);
    endfunction

    task automatic model_edge(input int k);
        ent_t n;
        bit   bad;
        int   w;
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) mmem[k][d] = '0;
            mcnt[k] = 0; mhead[k] = 0; pend[k] = 0;
            return;
        end
        if (dec_pop[k]) begin
            mhead[k] = (mhead[k] + 1) % 4;
            mcnt[k]--;
            if (mcnt[k] > 0) hstart[k] = cyc + 1;
        end
        if (dec_acc[k]) begin
            bad  = addr_bad(addr[k]);
            w    = bad ? 0 : int'((longint'(addr[k]) - longint'(BASE)) / 4);
            n.id = aid[k];
            n.e  = bad;
            n.d  = (we[k] || bad) ? 32'h0 : mmem[k][w];
            if (we[k] && !bad)
                for (int i = 0; i < 4; i++)
                    if (be[k][i]) mmem[k][w][8*i +: 8] = wdata[k][8*i +: 8];
            mq[k][(mhead[k] + mcnt[k]) % 4] = n;
            mcnt[k]++;
            if (mcnt[k] == 1) hstart[k] = cyc + 1;
            pend[k] = 0;
        end else if (req[k]) pend[k]++;
        else pend[k] = 0;
    endtask

    // Compare process: check on the falling edge, advance the model on the rising edge.
    initial begin
        cyc = 0;
        for (int k = 0; k < NI; k++) begin
            mcnt[k] = 0; mhead[k] = 0; pend[k] = 0; hstart[k] = 0; nresp[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                bit   eg, ev;
                ent_t h;
                eg = !rst && req[k] && !stall[k] && (pend[k] >= gw(k)) && (mcnt[k] < MO);
                ev = !rst && (mcnt[k] > 0) && (cyc - hstart[k] == longint'(rw(k)));
                h  = ev ? mq[k][mhead[k]] : '0;
                chk("gnt", k, 32'(gnt[k]), 32'(eg));
                chk("rvalid", k, 32'(rvalid[k]), 32'(ev));
                chk("rdata", k, rdata[k], h.d);
                chk("rid", k, 32'(rid[k]), 32'(h.id));
                chk("err", k, 32'(err[k]), 32'(h.e));
                if (rvalid[k] === 1'b1) begin
                    rid_hist[k][nresp[k] % 4] = rid[k];
                    obs_d[k] = rdata[k]; obs_id[k] = rid[k]; obs_e[k] = err[k];
                    nresp[k]++;
                end
                dec_acc[k] = eg;
                dec_pop[k] = ev;
            end
            @(posedge clk);
            for (int k = 0; k < NI; k++) model_edge(k);
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [AID_W-1:0] id, input int sc,
                         output int waited);
        bit g;
        g = 1'b0;
        waited = -1;
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b; aid[k] = id;
        for (int n = 0; n < 64; n++) begin
            stall[k] = (n < sc);
            @(negedge clk);
            g = gnt[k];
            @(posedge clk);
            #1;
            if (g) begin waited = n; break; end
        end
        stall[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0;
        if (g) issued[k]++;
        else begin
            checks++; errors++;
            $display("FAIL grant_timeout dut%0d: got no gnt expected gnt within 64 cycles", k);
        end
    endtask

    task automatic wait_all(input int k);
        for (int n = 0; n < 100 && nresp[k] < issued[k]; n++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (nresp[k] != issued[k]) begin
            errors++;
            $display("FAIL resp_timeout dut%0d: got %0d responses expected %0d", k, nresp[k], issued[k]);
        end
    endtask

    task automatic single(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic [AID_W-1:0] id);
        int wt;
        issue(k, w, a, d, b, id, 0, wt);
        wait_all(k);
    endtask

    task automatic rand_run(input int k);
        for (int t = 0; t < 40; t++) begin
            int          wt, sel;
            logic [31:0] a;
            sel = int'($urandom_range(0, 9));
            a   = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            if (sel == 0)      a = a + 32'($urandom_range(1, 3));
            else if (sel == 1) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            else if (sel == 2) a = BASE - 32'd4;
            issue(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), AID_W'($urandom),
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0, wt);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_all(k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int wt, b;
        for (int k = 0; k < NI; k++) begin
            req[k] = 0; we[k] = 0; stall[k] = 0; be[k] = 0; addr[k] = 0;
            wdata[k] = 0; aid[k] = 0; issued[k] = 0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("reset_gnt", 0, 32'(gnt[0]), 32'd0);
        chk("reset_rvalid", 0, 32'(rvalid[0]), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Full-word write then read: response in the cycle after grant.
        issue(0, 1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 4'd1, 0, wt);
        issue(0, 0, BASE + 32'h10, 32'h0, 4'hF, 4'd2, 0, wt);
        @(negedge clk);
        chk("lat_rvalid", 0, 32'(rvalid[0]), 32'd1);
        chk("lat_rdata", 0, rdata[0], 32'hDEAD_BEEF);
        chk("lat_rid", 0, 32'(rid[0]), 32'd2);
        chk("lat_err", 0, 32'(err[0]), 32'd0);
        @(posedge clk); #1;
        wait_all(0);

        // Partial byte-enable merge.
        single(0, 1, BASE + 32'h20, 32'hAABB_CCDD, 4'hF, 4'd3);
        single(0, 1, BASE + 32'h20, 32'h1122_3344, 4'b0101, 4'd4);
        single(0, 0, BASE + 32'h20, 32'h0, 4'hF, 4'd5);
        chk("be_merge", 0, obs_d[0], 32'hAA22_CC44);
        chk("be_merge_rid", 0, 32'(obs_id[0]), 32'd5);

        // Window and alignment errors; erroneous writes must not touch memory.
        single(0, 1, BASE, 32'h1234_5678, 4'hF, 4'd6);
        single(0, 0, BASE + 32'(4 * DEPTH), 32'h0, 4'hF, 4'd7);
        chk("oob_err", 0, 32'(obs_e[0]), 32'd1);
        chk("oob_rdata", 0, obs_d[0], 32'h0);
        single(0, 0, BASE + 32'h2, 32'h0, 4'hF, 4'd8);
        chk("misalign_err", 0, 32'(obs_e[0]), 32'd1);
        chk("misalign_rdata", 0, obs_d[0], 32'h0);
        single(0, 0, BASE - 32'd4, 32'h0, 4'hF, 4'd9);
        chk("below_err", 0, 32'(obs_e[0]), 32'd1);
        single(0, 1, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 4'd10);
        chk("oob_wr_err", 0, 32'(obs_e[0]), 32'd1);
        single(0, 1, BASE + 32'h2, 32'hFFFF_FFFF, 4'hF, 4'd11);
        chk("misalign_wr_err", 0, 32'(obs_e[0]), 32'd1);
        single(0, 0, BASE, 32'h0, 4'hF, 4'd12);
        chk("word0_kept", 0, obs_d[0], 32'h1234_5678);
        chk("word0_err", 0, 32'(obs_e[0]), 32'd0);
        single(0, 1, BASE + 32'(4 * DEPTH - 4), 32'h0BAD_F00D, 4'hF, 4'd13);
        single(0, 0, BASE + 32'(4 * DEPTH - 4), 32'h0, 4'hF, 4'd14);
        chk("last_word", 0, obs_d[0], 32'h0BAD_F00D);
        chk("last_word_err", 0, 32'(obs_e[0]), 32'd0);

        // Outstanding limit with delayed responses.
        for (int i = 0; i < 4; i++) single(1, 1, BASE + 32'(4 * i), 32'h100 + 32'(i), 4'hF, 4'd15);
        b = nresp[1];
        issue(1, 0, BASE + 32'd0, 32'h0, 4'hF, 4'd0, 0, wt);
        chk("outst_w0", 1, 32'(wt), 32'd0);
        issue(1, 0, BASE + 32'd4, 32'h0, 4'hF, 4'd1, 0, wt);
        chk("outst_w1", 1, 32'(wt), 32'd0);
        issue(1, 0, BASE + 32'd8, 32'h0, 4'hF, 4'd2, 0, wt);
        chk("outst_w2", 1, 32'(wt), 32'd3);
        issue(1, 0, BASE + 32'd12, 32'h0, 4'hF, 4'd3, 0, wt);
        chk("outst_w3", 1, 32'(wt), 32'd3);
        wait_all(1);
        for (int i = 0; i < 4; i++) chk("rid_order", 1, 32'(rid_hist[1][(b + i) % 4]), 32'(i));
        chk("outst_last_data", 1, obs_d[1], 32'h103);

        // Grant wait states and stall.
        issue(2, 0, BASE, 32'h0, 4'hF, 4'd1, 0, wt);
        chk("gnt_wait", 2, 32'(wt), 32'd2);
        issue(2, 0, BASE, 32'h0, 4'hF, 4'd2, 4, wt);
        chk("stall_wait", 2, 32'(wt), 32'd4);
        issue(2, 0, BASE, 32'h0, 4'hF, 4'd3, 1, wt);
        chk("stall_short", 2, 32'(wt), 32'd2);
        wait_all(2);

        // One-cycle reset with two responses queued.
        single(1, 1, BASE + 32'd12, 32'hCAFE_0003, 4'hF, 4'd6);
        wait_all(0);
        issue(1, 0, BASE + 32'd12, 32'h0, 4'hF, 4'd7, 0, wt);
        issue(1, 0, BASE + 32'd12, 32'h0, 4'hF, 4'd8, 0, wt);
        b = nresp[1];
        rst = 1'b1;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = BASE + 32'h10; aid[0] = 4'd9;
        @(negedge clk);
        chk("gnt_in_reset", 0, 32'(gnt[0]), 32'd0);
        chk("rvalid_in_reset", 1, 32'(rvalid[1]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req[0] = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("dropped_resp", 1, 32'(nresp[1]), 32'(b));
        issued[1] = nresp[1];
        single(1, 0, BASE + 32'd12, 32'h0, 4'hF, 4'd10);
        chk("reset_mem1", 1, obs_d[1], 32'h0);
        single(0, 0, BASE + 32'h10, 32'h0, 4'hF, 4'd11);
        chk("reset_mem0", 0, obs_d[0], 32'h0);

        // Randomized traffic on all three instances concurrently.
        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
        join

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
